// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core: one shared ALU, one unified memory port with a req/ready handshake.
// Optional feature macro MIPS_BNE_EN: when defined, opcode 0x05 (bne) is legal; otherwise it halts.
//   state  | meaning
//   FETCH  | request instruction at pc; on ready latch IR, pc += 4
//   DECODE | read rs/rt into A/B, precompute branch target into ALUOut
//   EXEC   | ALU op, load/store address, or resolve beq/bne/j
//   MEM    | data access at ALUOut
//   WB     | register file write
//   HALT   | illegal opcode seen; idle until reset
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_ready,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_ula_result,
    output logic              o_retire,
    output logic              o_halted
);

`ifdef MIPS_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      r_state, w_next;
    logic        r_active;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic [31:0] r_regs [32];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_wr_addr;
    logic [31:0] w_sext, w_alu_b, w_alu_y, w_wr_data, w_addr;
    logic        w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_j;
    logic        w_legal, w_branch, w_taken, w_req, w_accept;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_sext  = {{16{r_ir[15]}}, r_ir[15:0]};

    assign w_is_r    = (w_op == OP_RTYPE);
    assign w_is_addi = (w_op == OP_ADDI);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_beq  = (w_op == OP_BEQ);
    assign w_is_bne  = BNE_EN && (w_op == OP_BNE);
    assign w_is_j    = (w_op == OP_J);
    assign w_branch  = w_is_beq || w_is_bne;
    assign w_taken   = (w_is_beq && (r_a == r_b)) || (w_is_bne && (r_a != r_b));
    assign w_legal   = (w_is_r && (w_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}))
                     || w_is_addi || w_is_lw || w_is_sw || w_branch || w_is_j;

    // Shared ALU: R-type uses B, everything else adds the sign-extended immediate
    always_comb begin
        w_alu_b = w_is_r ? r_b : w_sext;
        w_alu_y = r_a + w_alu_b;
        if (w_is_r) begin
            case (w_funct)
                FN_SUB:  w_alu_y = r_a - w_alu_b;
                FN_AND:  w_alu_y = r_a & w_alu_b;
                FN_OR:   w_alu_y = r_a | w_alu_b;
                FN_SLT:  w_alu_y = {31'd0, ($signed(r_a) < $signed(w_alu_b))};
                default: w_alu_y = r_a + w_alu_b;
            endcase
        end
    end

    assign w_wr_addr = w_is_r ? w_rd : w_rt;
    assign w_wr_data = w_is_lw ? r_mdr : r_aluout;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_FETCH;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_active <= 1'b1;
        end
    end

    // r_active keeps the port quiet while reset is held and drops it the instant reset asserts
    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        o_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = r_active;
                if (r_active && i_mem_ready) w_next = S_DECODE;
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (w_branch || w_is_j) begin
                    o_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_req = 1'b1;
                if (i_mem_ready) begin
                    if (w_is_sw) begin
                        o_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                o_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    assign w_accept = w_req && i_mem_ready;
    assign w_addr   = (r_state == S_MEM) ? r_aluout : r_pc;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_aluout <= 32'd0;
            r_mdr    <= 32'd0;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_accept) begin
                        r_ir <= i_mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    r_a      <= r_regs[w_rs];
                    r_b      <= r_regs[w_rt];
                    r_aluout <= r_pc + {w_sext[29:0], 2'b00};
                end
                S_EXEC: begin
                    if (w_branch) begin
                        if (w_taken) r_pc <= r_aluout;
                    end else if (w_is_j) begin
                        r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    end else begin
                        r_aluout <= w_alu_y;
                    end
                end
                S_MEM: begin
                    if (w_accept && !w_is_sw) r_mdr <= i_mem_rdata;
                end
                S_WB: begin
                    if (w_wr_addr != 5'd0) r_regs[w_wr_addr] <= w_wr_data;
                end
                default: ;
            endcase
        end
    end

    assign o_mem_req    = w_req;
    assign o_mem_we     = (r_state == S_MEM) && w_is_sw;
    assign o_mem_addr   = w_addr[ADDR_W-1:0];
    assign o_mem_wdata  = r_b;
    assign o_pc         = r_pc;
    assign o_ula_result = r_aluout;
    assign o_halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_mips_multicycle.sv
// Scoreboard bench for mips_multicycle: an ISA-level interpreter predicts every memory
// transaction and the retire count; a monitor checks the DUT port against that queue.
module tb_mips_multicycle;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        o_mem_req, o_mem_we, i_mem_ready, o_retire, o_halted;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata, o_pc, o_ula_result;

    logic [31:0] prog [256];
    logic [31:0] mem  [256];
    logic [31:0] mm   [256];
    txn_t        exp_q [$];
    int          tests = 0, fails = 0;
    int          wait_mode = 0, wcnt = -1, ret_cnt = 0;

    mips_multicycle dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ready (i_mem_ready),
        .o_pc        (o_pc),
        .o_ula_result(o_ula_result),
        .o_retire    (o_retire),
        .o_halted    (o_halted)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Memory: responds at the falling edge; wait states per transaction set by wait_mode
    always @(negedge i_clock) begin
        if (i_reset && o_mem_req) begin
            if (wcnt < 0) wcnt = (wait_mode == 0) ? 0 : (wait_mode == 1) ? 3 : int'($urandom_range(0, 3));
            if (wcnt == 0) begin
                i_mem_ready = 1'b1;
                if (o_mem_we) mem[o_mem_addr[9:2]] = o_mem_wdata;
                else          i_mem_rdata = mem[o_mem_addr[9:2]];
                wcnt = -1;
            end else begin
                i_mem_ready = 1'b0;
                i_mem_rdata = $urandom;
                wcnt--;
            end
        end else begin
            wcnt = -1;
            i_mem_rdata = $urandom;
            i_mem_ready = (wait_mode == 2) && ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: pops one expected transaction per accepted request; checks request stability
    logic        prev_wait = 1'b0, prev_we;
    logic [31:0] prev_addr, prev_wdata;
    txn_t        mon_e;
    always begin
        @(negedge i_clock);
        #2;
        if (i_reset) begin
            if (prev_wait && o_mem_req) begin
                tests++;
                if (o_mem_we !== prev_we || o_mem_addr !== prev_addr || o_mem_wdata !== prev_wdata) begin
                    fails++;
                    $display("FAIL req_stable: got we=%0b addr=%h wdata=%h, held we=%0b addr=%h wdata=%h",
                             o_mem_we, o_mem_addr, o_mem_wdata, prev_we, prev_addr, prev_wdata);
                end
            end
            if (o_mem_req && i_mem_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL mem_txn: got unexpected we=%0b addr=%h, required no transaction",
                             o_mem_we, o_mem_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (o_mem_we !== mon_e.we || o_mem_addr !== mon_e.addr ||
                        (mon_e.we && o_mem_wdata !== mon_e.data)) begin
                        fails++;
                        $display("FAIL mem_txn: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                                 o_mem_we, o_mem_addr, o_mem_wdata, mon_e.we, mon_e.addr, mon_e.data);
                    end
                end
            end
            if (o_retire) ret_cnt++;
            prev_wait  = o_mem_req && !i_mem_ready;
            prev_we    = o_mem_we;
            prev_addr  = o_mem_addr;
            prev_wdata = o_mem_wdata;
        end else begin
            prev_wait = 1'b0;
        end
    end

    // Instruction-set interpreter: pushes every fetch/load/store in program order
    task automatic model_run(output int nret);
        logic [31:0] regs [32];
        logic [31:0] pc, ir, a, b, simm, addr;
        bit          legal;
        pc   = RESET_PC;
        nret = 0;
        for (int r = 0; r < 32; r++) regs[r] = 32'd0;
        for (int n = 0; n < 2000; n++) begin
            exp_q.push_back('{we: 1'b0, addr: pc, data: 32'd0});
            ir    = mm[pc[9:2]];
            pc    = pc + 32'd4;
            a     = regs[ir[25:21]];
            b     = regs[ir[20:16]];
            simm  = {{16{ir[15]}}, ir[15:0]};
            legal = 1'b1;
            case (ir[31:26])
                6'h00: case (ir[5:0])
                    6'h20: regs[ir[15:11]] = a + b;
                    6'h22: regs[ir[15:11]] = a - b;
                    6'h24: regs[ir[15:11]] = a & b;
                    6'h25: regs[ir[15:11]] = a | b;
                    6'h2A: regs[ir[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: legal = 1'b0;
                endcase
                6'h08: regs[ir[20:16]] = a + simm;
                6'h23: begin
                    addr = a + simm;
                    exp_q.push_back('{we: 1'b0, addr: addr, data: 32'd0});
                    regs[ir[20:16]] = mm[addr[9:2]];
                end
                6'h2B: begin
                    addr = a + simm;
                    exp_q.push_back('{we: 1'b1, addr: addr, data: b});
                    mm[addr[9:2]] = b;
                end
                6'h04: if (a == b) pc = pc + (simm << 2);
`ifdef MIPS_BNE_EN
                6'h05: if (a != b) pc = pc + (simm << 2);
`endif
                6'h02: pc = {pc[31:28], ir[25:0], 2'b00};
                default: legal = 1'b0;
            endcase
            if (!legal) break;
            regs[0] = 32'd0;
            nret++;
        end
    endtask

    task automatic load_directed();
        for (int i = 0; i < 256; i++) prog[i] = (i >= 128) ? $urandom : 32'd0;
        prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1]  = enc_r(5'd1, 5'd1, 5'd2, 6'h20);
        prog[2]  = enc_i(6'h2B, 5'd0, 5'd2, 16'd8);
        prog[3]  = enc_i(6'h23, 5'd0, 5'd3, 16'd8);
        prog[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd3);
        prog[5]  = enc_i(6'h08, 5'd0, 5'd7, 16'd7);
        prog[6]  = enc_i(6'h08, 5'd0, 5'd7, 16'd7);
        prog[7]  = enc_i(6'h08, 5'd0, 5'd7, 16'd7);
        prog[8]  = enc_i(6'h04, 5'd1, 5'd0, 16'd2);
        prog[9]  = {6'h02, 26'h10};
        prog[16] = enc_r(5'd0, 5'd1, 5'd5, 6'h22);
        prog[17] = enc_r(5'd5, 5'd1, 5'd6, 6'h2A);
        prog[18] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0200);
        prog[19] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0204);
        prog[20] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0208);
        prog[21] = enc_i(6'h05, 5'd1, 5'd0, 16'd1);
        prog[22] = enc_i(6'h2B, 5'd0, 5'd1, 16'h020C);
        prog[23] = 32'hFC00_0000;
    endtask

    task automatic load_random();
        logic [5:0]  fns [5];
        logic [4:0]  rs, rt, rd;
        logic [15:0] daddr;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int i = 0; i < 256; i++) prog[i] = (i >= 128) ? $urandom : 32'd0;
        for (int i = 0; i < 60; i++) begin
            rs    = 5'($urandom_range(0, 7));
            rt    = 5'($urandom_range(0, 7));
            rd    = 5'($urandom_range(0, 7));
            daddr = 16'(32'h200 + 4 * $urandom_range(0, 127));
            case ($urandom_range(0, 9))
                0, 1:    prog[i] = enc_i(6'h08, rs, rt, 16'($urandom));
                2, 3, 4: prog[i] = enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
                5, 6:    prog[i] = enc_i(6'h23, 5'd0, rt, daddr);
                7:       prog[i] = enc_i(6'h2B, 5'd0, rt, daddr);
                default: prog[i] = enc_i(6'h04, rs, rt, 16'($urandom_range(0, 2)));
            endcase
        end
        for (int r = 1; r < 8; r++) prog[59 + r] = enc_i(6'h2B, 5'd0, 5'(r), 16'(32'h300 + 4 * r));
        prog[67] = 32'hFC00_0000;
    endtask

    task automatic run_prog(input int mode, input bit directed);
        int  nret, c, nseen;
        bit  done;
        wait_mode = mode;
        for (int i = 0; i < 256; i++) begin
            mem[i] = prog[i];
            mm[i]  = prog[i];
        end
        exp_q.delete();
        if (mode == 1) begin
            @(negedge i_clock);
            i_reset = 1'b0;
            @(negedge i_clock);
            i_reset = 1'b1;
            @(negedge i_clock);
            @(negedge i_clock);
            #1;
            check("req_pending", {31'd0, o_mem_req}, 32'd1);
            i_reset = 1'b0;
            #1;
            check("req_drop_on_reset", {31'd0, o_mem_req}, 32'd0);
        end
        @(negedge i_clock);
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clock);
            #1;
            check("reset_req", {31'd0, o_mem_req}, 32'd0);
        end
        check("reset_pc", o_pc, RESET_PC);
        check("reset_halted", {31'd0, o_halted}, 32'd0);
        check("reset_retire", {31'd0, o_retire}, 32'd0);
        check("reset_ula", o_ula_result, 32'd0);
        model_run(nret);
        ret_cnt = 0;
        @(negedge i_clock);
        i_reset = 1'b1;
        c = 0;
        nseen = 0;
        done = 1'b0;
        while (!done && c < 4000) begin
            @(negedge i_clock);
            #3;
            c++;
            if (c == 1) begin
                check("first_req", {31'd0, o_mem_req}, 32'd1);
                check("first_addr", o_mem_addr, RESET_PC);
            end
            if (directed && o_retire && nseen < 2) begin
                nseen++;
                if (nseen == 1) check("addi_ula", o_ula_result, 32'd5);
                if (nseen == 2) begin
                    check("add_ula", o_ula_result, 32'd10);
                    check("two_instr_cycles", c, (mode == 1) ? 32'd14 : 32'd8);
                end
            end
            done = (exp_q.size() == 0) && o_halted;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL run_timeout: got %0d pending transactions after %0d cycles, required 0",
                     exp_q.size(), c);
        end
        check("retire_count", ret_cnt, nret);
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clock);
            #3;
            check("halt_no_req", {31'd0, o_mem_req}, 32'd0);
            check("halt_held", {31'd0, o_halted}, 32'd1);
        end
    endtask

    initial begin
        i_mem_ready = 1'b0;
        i_mem_rdata = 32'd0;
        load_directed();
        run_prog(0, 1'b1);
        load_directed();
        run_prog(1, 1'b1);
        for (int r = 0; r < 4; r++) begin
            load_random();
            run_prog(2, 1'b0);
        end
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        check("reset_clears_halt", {31'd0, o_halted}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
